// File: rtl/dma_channel_ctrl.sv
// -----------------------------------------------------------------------------
// dma_channel_ctrl
//
// Single-channel fly-by DMA controller. The CPU programs a base address, a
// byte count and a direction; on START the channel waits for the device's
// DREQ, requests the bus with HOLD, and once HLDA is granted it moves one
// byte per bus handshake directly between device and memory:
//   DIR=0 : IOR + MEMW  (IO -> memory)
//   DIR=1 : MEMR + IOW  (memory -> IO)
//
// Optional build macro: DMA_TIMEOUT_EN
//   defined   : each wait for a TReady edge is bounded by TIMEOUT_CYCLES;
//               expiry abandons the transfer and sets the sticky err flag.
//   undefined : waits are unbounded and err is tied low.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   cfg_we         register write strobe (one cycle)
//   cfg_addr       register select: 0=BASE, 1=COUNT, 2=CTRL
//   cfg_wdata      register write data; CTRL[0]=START, CTRL[1]=DIR
//   DREQ           device DMA request (level)
//   DACK           DMA acknowledge to the device
//   HOLD / HLDA    bus request to / grant from the CPU
//   Address_Bus_o  memory address, valid while bus_oe is high
//   bus_oe         controller owns address bus, strobes and IReady
//   IOR/IOW/MEMR/MEMW  command strobes
//   IReady         initiator ready
//   TReady         target ready from memory/IO
//   busy           channel armed or transferring
//   tc             one-cycle terminal-count pulse
//   err            sticky timeout error
// -----------------------------------------------------------------------------
module dma_channel_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_wdata,
    input  logic              DREQ,
    output logic              DACK,
    output logic              HOLD,
    input  logic              HLDA,
    output logic [ADDR_W-1:0] Address_Bus_o,
    output logic              bus_oe,
    output logic              IOR,
    output logic              IOW,
    output logic              MEMR,
    output logic              MEMW,
    output logic              IReady,
    input  logic              TReady,
    output logic              busy,
    output logic              tc,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SETUP   = 3'd3;
    localparam logic [2:0] S_ASSERT  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic              r_ctrl_dir;
    logic              r_dir;        // direction latched for the active block
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_zero_tc;    // tc for a START with COUNT==0
    logic              w_start;
    logic              w_byte_done;  // target released: byte complete
    logic              w_timeout;
    logic              w_own;

    // START is only honoured from IDLE; anywhere else it is dropped.
    assign w_start     = cfg_we && (cfg_addr == 2'd2) && cfg_wdata[0] && (r_state == S_IDLE);
    assign w_byte_done = (r_state == S_RELEASE) && !TReady;

`ifdef DMA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to;
    logic            r_err;
    logic            w_waiting;

    // Waiting for the rising TReady edge in ASSERT or the falling edge in RELEASE.
    assign w_waiting = ((r_state == S_ASSERT) && !TReady) ||
                       ((r_state == S_RELEASE) && TReady);
    assign w_timeout = w_waiting && (r_to == TO_W'(TIMEOUT_CYCLES - 1));
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to  <= '0;
            r_err <= 1'b0;
        end else begin
            // Counter restarts on every state change so each edge gets a full budget.
            if (w_waiting && (w_state_next == r_state)) begin
                r_to <= r_to + TO_W'(1);
            end else begin
                r_to <= '0;
            end
            if (w_start) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && (r_count != '0)) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (DREQ) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (HLDA) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_next = S_ASSERT;
            end
            S_ASSERT: begin
                if (TReady) begin
                    w_state_next = S_RELEASE;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (w_byte_done) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = S_DONE;
                    end else if (!HLDA) begin
                        // Grant withdrawn: re-request before the next byte.
                        w_state_next = S_REQ;
                    end else if (DREQ) begin
                        w_state_next = S_SETUP;
                    end else begin
                        w_state_next = S_GAP;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (!HLDA) begin
                    w_state_next = S_REQ;
                end else if (DREQ) begin
                    w_state_next = S_SETUP;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_ctrl_dir <= 1'b0;
            r_dir      <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_zero_tc  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_zero_tc <= w_start && (r_count == '0);

            if (cfg_we && (r_state == S_IDLE)) begin
                case (cfg_addr)
                    2'd0:    r_base     <= ADDR_W'(cfg_wdata);
                    2'd1:    r_count    <= CNT_W'(cfg_wdata);
                    2'd2:    r_ctrl_dir <= cfg_wdata[1];
                    default: ;
                endcase
            end

            if (w_start) begin
                // Working copies; the programmed BASE/COUNT stay intact.
                r_addr <= r_base;
                r_cnt  <= r_count;
                r_dir  <= cfg_wdata[1];
            end else if (w_byte_done) begin
                // Advance only after IReady and TReady are both low.
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs decode straight from the state register, so a reset edge
    // clears every strobe together with the state.
    assign w_own         = (r_state == S_SETUP) || (r_state == S_ASSERT) || (r_state == S_RELEASE);
    assign bus_oe        = w_own;
    assign DACK          = w_own;
    assign IOR           = w_own && !r_dir;
    assign MEMW          = w_own && !r_dir;
    assign MEMR          = w_own && r_dir;
    assign IOW           = w_own && r_dir;
    assign IReady        = (r_state == S_ASSERT);
    assign HOLD          = (r_state >= S_REQ) && (r_state <= S_GAP);
    assign busy          = (r_state >= S_ARMED) && (r_state <= S_GAP);
    assign tc            = (r_state == S_DONE) || r_zero_tc;
    assign Address_Bus_o = w_own ? r_addr : '0;

endmodule

// File: tb/tb_dma_channel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_channel_ctrl
//
// Directed bench for dma_channel_ctrl. A CPU model grants HLDA two cycles
// after HOLD, and a target model follows IReady with a one-cycle lag on
// TReady. A monitor records every handshake (address plus strobes at the
// rising edge of IReady) and counts tc pulses and strobe cycles; the
// directed sequence compares those records against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dma_channel_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'd0;
    logic        DREQ = 1'b0;
    logic        HLDA = 1'b0;
    logic        TReady = 1'b0;
    logic        DACK, HOLD, bus_oe, IOR, IOW, MEMR, MEMW, IReady, busy, tc, err;
    logic [15:0] Address_Bus_o;
    logic [26:0] all_outs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_channel_ctrl #(
        .ADDR_W         (16),
        .CNT_W          (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .DREQ          (DREQ),
        .DACK          (DACK),
        .HOLD          (HOLD),
        .HLDA          (HLDA),
        .Address_Bus_o (Address_Bus_o),
        .bus_oe        (bus_oe),
        .IOR           (IOR),
        .IOW           (IOW),
        .MEMR          (MEMR),
        .MEMW          (MEMW),
        .IReady        (IReady),
        .TReady        (TReady),
        .busy          (busy),
        .tc            (tc),
        .err           (err)
    );

    assign all_outs = {DACK, HOLD, bus_oe, IOR, IOW, MEMR, MEMW, IReady, busy, tc, err, Address_Bus_o};

    // CPU and target models, updated on the falling edge.
    logic tr_en = 1'b1;
    logic ir_d = 1'b0;
    logic h_d1 = 1'b0;
    logic h_d2 = 1'b0;
    always @(negedge clk) begin
        TReady = ir_d;
        ir_d   = IReady & tr_en;
        HLDA   = h_d2;
        h_d2   = h_d1;
        h_d1   = HOLD;
    end

    // Monitor, sampled just after each rising edge.
    int          hs_n = 0;
    logic [15:0] hs_addr [64];
    logic [5:0]  hs_flags [64];   // {DACK, bus_oe, IOR, IOW, MEMR, MEMW}
    int          tc_cnt = 0;
    int          hold_cyc = 0;
    int          ior_cyc = 0;
    int          memw_cyc = 0;
    logic        busy_at_tc = 1'b1;
    logic        prev_ir = 1'b0;
    always @(posedge clk) begin
        #1;
        if (IReady && !prev_ir && hs_n < 64) begin
            hs_addr[hs_n]  = Address_Bus_o;
            hs_flags[hs_n] = {DACK, bus_oe, IOR, IOW, MEMR, MEMW};
            hs_n++;
        end
        prev_ir = IReady;
        if (tc) begin
            tc_cnt++;
            busy_at_tc = busy;
        end
        if (HOLD) hold_cyc++;
        if (IOR)  ior_cyc++;
        if (MEMW) memw_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_tc(input int t0, input string tag);
        for (int i = 0; i < 300 && tc_cnt == t0; i++) @(negedge clk);
        chk(tag, tc_cnt - t0, 1);
    endtask

    task automatic wait_ir(input string tag);
        for (int i = 0; i < 100 && !IReady; i++) @(negedge clk);
        chk(tag, {31'd0, IReady}, 1);
    endtask

    initial begin
        int t0, b, h0, i0, m0;
        logic [15:0] exp_a3 [3];
        logic [15:0] exp_a4 [4];

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", {5'd0, all_outs}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // IO -> memory, 3 bytes from 1003
        exp_a3 = '{16'd1003, 16'd1004, 16'd1005};
        cfg_write(2'd0, 16'd1003);
        cfg_write(2'd1, 16'd3);
        DREQ = 1'b1;
        t0 = tc_cnt;
        b  = hs_n;
        cfg_write(2'd2, 16'h0001);
        chk("t1_busy", {31'd0, busy}, 1);
        wait_tc(t0, "t1_tc");
        chk("t1_busy_at_tc", {31'd0, busy_at_tc}, 0);
        chk("t1_hs_count", hs_n - b, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), {16'd0, hs_addr[b+i]}, {16'd0, exp_a3[i]});
            chk($sformatf("t1_flags%0d", i), {26'd0, hs_flags[b+i]}, 32'b111001);
        end
        @(negedge clk);
        chk("t1_tc_one_cycle", tc_cnt - t0, 1);
        chk("t1_idle_outs", {5'd0, all_outs}, 0);

        // Memory -> IO, 2 bytes from 0x0010
        cfg_write(2'd0, 16'h0010);
        cfg_write(2'd1, 16'd2);
        t0 = tc_cnt;
        b  = hs_n;
        i0 = ior_cyc;
        m0 = memw_cyc;
        cfg_write(2'd2, 16'h0003);
        wait_tc(t0, "t2_tc");
        chk("t2_hs_count", hs_n - b, 2);
        chk("t2_addr0", {16'd0, hs_addr[b]},   32'h0010);
        chk("t2_addr1", {16'd0, hs_addr[b+1]}, 32'h0011);
        chk("t2_flags0", {26'd0, hs_flags[b]},   32'b110110);
        chk("t2_flags1", {26'd0, hs_flags[b+1]}, 32'b110110);
        chk("t2_no_ior",  ior_cyc - i0, 0);
        chk("t2_no_memw", memw_cyc - m0, 0);

        // COUNT == 0: tc the cycle after START, no bus request
        repeat (3) @(negedge clk);
        cfg_write(2'd1, 16'd0);
        h0 = hold_cyc;
        t0 = tc_cnt;
        cfg_write(2'd2, 16'h0001);
        chk("t3_tc_next", {31'd0, tc}, 1);
        chk("t3_busy", {31'd0, busy}, 0);
        @(negedge clk);
        chk("t3_tc_low", {31'd0, tc}, 0);
        repeat (5) @(negedge clk);
        chk("t3_no_hold", hold_cyc - h0, 0);
        chk("t3_tc_count", tc_cnt - t0, 1);

        // DREQ drops after byte 1 of 4 -> GAP, then resumes
        exp_a4 = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        cfg_write(2'd0, 16'h0100);
        cfg_write(2'd1, 16'd4);
        DREQ = 1'b1;
        t0 = tc_cnt;
        b  = hs_n;
        cfg_write(2'd2, 16'h0001);
        for (int i = 0; i < 100 && hs_n == b; i++) @(negedge clk);
        DREQ = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_gap_hs", hs_n - b, 1);
        chk("t4_gap_hold", {31'd0, HOLD}, 1);
        chk("t4_gap_dack", {31'd0, DACK}, 0);
        chk("t4_gap_oe", {31'd0, bus_oe}, 0);
        chk("t4_gap_busy", {31'd0, busy}, 1);
        DREQ = 1'b1;
        wait_tc(t0, "t4_tc");
        chk("t4_hs_count", hs_n - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_addr%0d", i), {16'd0, hs_addr[b+i]}, {16'd0, exp_a4[i]});
        end

        // Reset while in ASSERT
        repeat (3) @(negedge clk);
        cfg_write(2'd0, 16'h2000);
        cfg_write(2'd1, 16'd5);
        t0 = tc_cnt;
        cfg_write(2'd2, 16'h0001);
        wait_ir("t5_reach_assert");
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_outs", {5'd0, all_outs}, 0);
        chk("t5_no_tc", tc_cnt - t0, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Address wrap after reset: 0xFFFF then 0x0000
        cfg_write(2'd0, 16'hFFFF);
        cfg_write(2'd1, 16'd2);
        t0 = tc_cnt;
        b  = hs_n;
        cfg_write(2'd2, 16'h0001);
        wait_tc(t0, "t5_tc");
        chk("t5_hs_count", hs_n - b, 2);
        chk("t5_addr0", {16'd0, hs_addr[b]},   32'hFFFF);
        chk("t5_addr1", {16'd0, hs_addr[b+1]}, 32'h0000);
        chk("t5_flags0", {26'd0, hs_flags[b]}, 32'b111001);
        chk("t5_err", {31'd0, err}, 0);

`ifdef DMA_TIMEOUT_EN
        // TReady never answers: timeout after 8 ASSERT cycles
        repeat (3) @(negedge clk);
        tr_en = 1'b0;
        cfg_write(2'd1, 16'd1);
        t0 = tc_cnt;
        cfg_write(2'd2, 16'h0001);
        wait_ir("t6_reach_assert");
        repeat (7) @(negedge clk);
        chk("t6_err_before", {31'd0, err}, 0);
        chk("t6_ir_before", {31'd0, IReady}, 1);
        @(negedge clk);
        chk("t6_err_set", {31'd0, err}, 1);
        chk("t6_hold_low", {31'd0, HOLD}, 0);
        chk("t6_busy_low", {31'd0, busy}, 0);
        chk("t6_no_tc", tc_cnt - t0, 0);
        repeat (4) @(negedge clk);
        chk("t6_err_sticky", {31'd0, err}, 1);
        tr_en = 1'b1;
        cfg_write(2'd1, 16'd0);
        cfg_write(2'd2, 16'h0001);
        chk("t6_err_cleared", {31'd0, err}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
